// File: rtl/wb_regfile.sv
// Writeback-stage register file: 2^ADDR_W registers, two combinational read
// ports with write-through bypass, register 0 hardwired to zero, commit counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_WB,
  input  logic              write_Data_Src_mux_WB,
  input  logic              Set_Less_than_inst_WB,
  input  logic              STL_WB,
  input  logic [ADDR_W-1:0] Reg_write_num_WB,
  input  logic [DATA_W-1:0] Write_regfile_Source_1,
  input  logic [DATA_W-1:0] Write_regfile_Source_2,
  input  logic [ADDR_W-1:0] rs_num,
  input  logic [ADDR_W-1:0] rt_num,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       write_count
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_reg [NREGS];
  logic [31:0]       write_count_reg;
  logic              commit;

  logic [ADDR_W-1:0] rd_num  [2];
  logic [DATA_W-1:0] rd_data [2];

  always_comb begin
    wb_data = Write_regfile_Source_1;
    if (Set_Less_than_inst_WB)
      wb_data = {{(DATA_W-1){1'b0}}, STL_WB};
    else if (write_Data_Src_mux_WB)
      wb_data = Write_regfile_Source_2;
  end

  // Writes to register 0 are neither stored nor counted.
  assign commit = reg_write_WB && (Reg_write_num_WB != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_reg[i] <= '0;
      write_count_reg <= '0;
    end else if (commit) begin
      regs_reg[Reg_write_num_WB] <= wb_data;
      write_count_reg            <= write_count_reg + 32'd1;
    end
  end

  assign rd_num[0] = rs_num;
  assign rd_num[1] = rt_num;

  // Bypass stays live during reset so an in-flight WB value is still visible.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        if (rd_num[gi] == '0)
          rd_data[gi] = '0;
        else if (commit && (rd_num[gi] == Reg_write_num_WB))
          rd_data[gi] = wb_data;
        else
          rd_data[gi] = regs_reg[rd_num[gi]];
      end
    end
  endgenerate

  assign rs_data     = rd_data[0];
  assign rt_data     = rd_data[1];
  assign write_count = write_count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: writeback mux, bypass, r0, counter and reset.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_WB;
  logic        write_Data_Src_mux_WB;
  logic        Set_Less_than_inst_WB;
  logic        STL_WB;
  logic [4:0]  Reg_write_num_WB;
  logic [31:0] Write_regfile_Source_1;
  logic [31:0] Write_regfile_Source_2;
  logic [4:0]  rs_num;
  logic [4:0]  rt_num;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic [31:0] write_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .reg_write_WB           (reg_write_WB),
    .write_Data_Src_mux_WB  (write_Data_Src_mux_WB),
    .Set_Less_than_inst_WB  (Set_Less_than_inst_WB),
    .STL_WB                 (STL_WB),
    .Reg_write_num_WB       (Reg_write_num_WB),
    .Write_regfile_Source_1 (Write_regfile_Source_1),
    .Write_regfile_Source_2 (Write_regfile_Source_2),
    .rs_num                 (rs_num),
    .rt_num                 (rt_num),
    .rs_data                (rs_data),
    .rt_data                (rt_data),
    .wb_data                (wb_data),
    .write_count            (write_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_num = 5'(i);
      rt_num = 5'(31 - i);
      #1;
      n_checks++;
      if (rs_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rs[%0d]: got %h expected 00000000", i, rs_data);
      end
      n_checks++;
      if (rt_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rt[%0d]: got %h expected 00000000", 31 - i, rt_data);
      end
    end
    n_checks++;
    if (write_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", write_count);
    end
    $display("test_reset: 32 addresses read, write_count=%0d", write_count);
  endtask

  task automatic test_alu_write();
    reg_write_WB = 1'b1; Reg_write_num_WB = 5'd5; write_Data_Src_mux_WB = 1'b0;
    Write_regfile_Source_1 = 32'h1234_5678; Write_regfile_Source_2 = 32'h0BAD_F00D;
    #1;
    n_checks++;
    if (wb_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL alu_wb_data: got %h expected 12345678", wb_data);
    end
    tick();
    reg_write_WB = 1'b0; rs_num = 5'd5;
    #1;
    n_checks++;
    if (rs_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL alu_r5: got %h expected 12345678", rs_data);
    end
    n_checks++;
    if (write_count !== 32'd1) begin
      n_fail++;
      $display("FAIL alu_count: got %0d expected 1", write_count);
    end
    $display("test_alu_write: r5=%h count=%0d", rs_data, write_count);
  endtask

  task automatic test_load_bypass();
    reg_write_WB = 1'b1; Reg_write_num_WB = 5'd7; write_Data_Src_mux_WB = 1'b1;
    Write_regfile_Source_1 = 32'h1111_1111; Write_regfile_Source_2 = 32'hDEAD_BEEF;
    rt_num = 5'd7; rs_num = 5'd5;
    #1;
    n_checks++;
    if (rt_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL load_bypass_rt: got %h expected deadbeef", rt_data);
    end
    n_checks++;
    if (rs_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL load_other_port: got %h expected 12345678", rs_data);
    end
    tick();
    reg_write_WB = 1'b0; Write_regfile_Source_2 = 32'h0;
    #1;
    n_checks++;
    if (rt_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL load_persist_r7: got %h expected deadbeef", rt_data);
    end
    n_checks++;
    if (write_count !== 32'd2) begin
      n_fail++;
      $display("FAIL load_count: got %0d expected 2", write_count);
    end
    $display("test_load_bypass: r7=%h count=%0d", rt_data, write_count);
  endtask

  task automatic test_slt();
    Set_Less_than_inst_WB = 1'b1; STL_WB = 1'b1; write_Data_Src_mux_WB = 1'b0;
    Write_regfile_Source_1 = 32'hFFFF_FFFF; Write_regfile_Source_2 = 32'hFFFF_FFFF;
    reg_write_WB = 1'b1; Reg_write_num_WB = 5'd3;
    #1;
    n_checks++;
    if (wb_data !== 32'h1) begin
      n_fail++;
      $display("FAIL slt_wb_src0: got %h expected 00000001", wb_data);
    end
    write_Data_Src_mux_WB = 1'b1;
    #1;
    n_checks++;
    if (wb_data !== 32'h1) begin
      n_fail++;
      $display("FAIL slt_wb_src1: got %h expected 00000001", wb_data);
    end
    tick();
    reg_write_WB = 1'b0; rs_num = 5'd3;
    #1;
    n_checks++;
    if (rs_data !== 32'h1) begin
      n_fail++;
      $display("FAIL slt_r3_one: got %h expected 00000001", rs_data);
    end
    STL_WB = 1'b0; reg_write_WB = 1'b1;
    tick();
    reg_write_WB = 1'b0;
    #1;
    n_checks++;
    if (rs_data !== 32'h0) begin
      n_fail++;
      $display("FAIL slt_r3_zero: got %h expected 00000000", rs_data);
    end
    n_checks++;
    if (write_count !== 32'd4) begin
      n_fail++;
      $display("FAIL slt_count: got %0d expected 4", write_count);
    end
    Set_Less_than_inst_WB = 1'b0; write_Data_Src_mux_WB = 1'b0;
    $display("test_slt: r3=%h count=%0d", rs_data, write_count);
  endtask

  task automatic test_r0();
    reg_write_WB = 1'b1; Reg_write_num_WB = 5'd0;
    Write_regfile_Source_1 = 32'hAAAA_AAAA; rs_num = 5'd0;
    #1;
    n_checks++;
    if (rs_data !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_same_cycle: got %h expected 00000000", rs_data);
    end
    tick();
    reg_write_WB = 1'b0;
    #1;
    n_checks++;
    if (rs_data !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_next_cycle: got %h expected 00000000", rs_data);
    end
    n_checks++;
    if (write_count !== 32'd4) begin
      n_fail++;
      $display("FAIL r0_count: got %0d expected 4", write_count);
    end
    $display("test_r0: r0=%h count=%0d", rs_data, write_count);
  endtask

  task automatic test_no_write();
    reg_write_WB = 1'b0; Reg_write_num_WB = 5'd5;
    Write_regfile_Source_1 = 32'hCAFE_F00D; Write_regfile_Source_2 = 32'hCAFE_F00D;
    rs_num = 5'd5;
    #1;
    n_checks++;
    if (rs_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL nowrite_no_bypass: got %h expected 12345678", rs_data);
    end
    tick();
    n_checks++;
    if (rs_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL nowrite_no_change: got %h expected 12345678", rs_data);
    end
    n_checks++;
    if (write_count !== 32'd4) begin
      n_fail++;
      $display("FAIL nowrite_count: got %0d expected 4", write_count);
    end
    $display("test_no_write: r5=%h count=%0d", rs_data, write_count);
  endtask

  task automatic test_back_to_back();
    reg_write_WB = 1'b1; Reg_write_num_WB = 5'd10; write_Data_Src_mux_WB = 1'b0;
    Write_regfile_Source_1 = 32'h0000_0001;
    tick();
    Write_regfile_Source_1 = 32'h0000_0002;
    tick();
    reg_write_WB = 1'b0; rs_num = 5'd10; rt_num = 5'd10;
    #1;
    n_checks++;
    if (rs_data !== 32'h2) begin
      n_fail++;
      $display("FAIL b2b_last_wins: got %h expected 00000002", rs_data);
    end
    reg_write_WB = 1'b1; Write_regfile_Source_1 = 32'h0000_0003;
    #1;
    n_checks++;
    if (rs_data !== 32'h3) begin
      n_fail++;
      $display("FAIL b2b_bypass_rs: got %h expected 00000003", rs_data);
    end
    n_checks++;
    if (rt_data !== 32'h3) begin
      n_fail++;
      $display("FAIL b2b_bypass_rt: got %h expected 00000003", rt_data);
    end
    tick();
    reg_write_WB = 1'b0;
    #1;
    n_checks++;
    if (write_count !== 32'd7) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 7", write_count);
    end
    $display("test_back_to_back: r10=%h count=%0d", rs_data, write_count);
  endtask

  task automatic test_reset_priority();
    reset = 1'b1; reg_write_WB = 1'b1; Reg_write_num_WB = 5'd9;
    Write_regfile_Source_1 = 32'h0000_0055; rs_num = 5'd9; rt_num = 5'd5;
    #1;
    n_checks++;
    if (rs_data !== 32'h55) begin
      n_fail++;
      $display("FAIL rstprio_bypass: got %h expected 00000055", rs_data);
    end
    tick();
    reset = 1'b0; reg_write_WB = 1'b0;
    #1;
    n_checks++;
    if (rs_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstprio_r9: got %h expected 00000000", rs_data);
    end
    n_checks++;
    if (rt_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstprio_r5_cleared: got %h expected 00000000", rt_data);
    end
    n_checks++;
    if (write_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rstprio_count: got %0d expected 0", write_count);
    end
    $display("test_reset_priority: r9=%h count=%0d", rs_data, write_count);
  endtask

  initial begin
    reset = 1'b1; reg_write_WB = 1'b0; write_Data_Src_mux_WB = 1'b0;
    Set_Less_than_inst_WB = 1'b0; STL_WB = 1'b0; Reg_write_num_WB = 5'd0;
    Write_regfile_Source_1 = 32'h0; Write_regfile_Source_2 = 32'h0;
    rs_num = 5'd0; rt_num = 5'd0;
    tick();
    tick();
    test_reset();
    test_alu_write();
    test_load_bypass();
    test_slt();
    test_r0();
    test_no_write();
    test_back_to_back();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32: register and datapath width.
REQ-002 Parameter ADDR_W, default 5: register-number width; there SHALL be 2^ADDR_W registers.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reg_write_WB  input  1  WB-stage write enable.
REQ-006 write_Data_Src_mux_WB  input  1  0 selects Write_regfile_Source_1 (ALU result); 1 selects Write_regfile_Source_2 (load data).
REQ-007 Set_Less_than_inst_WB  input  1  WB instruction is set-less-than.
REQ-008 STL_WB  input  1  set-less-than comparison result.
REQ-009 Reg_write_num_WB  input  ADDR_W  destination register number.
REQ-010 Write_regfile_Source_1  input  DATA_W  ALU result.
REQ-011 Write_regfile_Source_2  input  DATA_W  data-memory read data.
REQ-012 rs_num, rt_num  input  ADDR_W each  ID-stage read addresses.
REQ-013 rs_data, rt_data  output  DATA_W each  ID-stage read data.
REQ-014 wb_data  output  DATA_W  resolved writeback value (combinational).
REQ-015 write_count  output  32  number of committed register writes since reset.

Function
REQ-016 wb_data SHALL be {(DATA_W-1)'b0, STL_WB} when Set_Less_than_inst_WB=1, regardless of write_Data_Src_mux_WB.
REQ-017 Otherwise, wb_data SHALL be Write_regfile_Source_2 when write_Data_Src_mux_WB=1, else Write_regfile_Source_1.
REQ-018 A write commits at the rising edge when reg_write_WB=1 and Reg_write_num_WB!=0: register[Reg_write_num_WB] <= wb_data.
REQ-019 Register 0 SHALL read as 0 at all times; writes to it are discarded and not counted.
REQ-020 Reads SHALL be combinational, with zero-cycle latency from rs_num/rt_num.
REQ-021 Write-through bypass: if reg_write_WB=1, Reg_write_num_WB!=0, and Reg_write_num_WB equals a read address, that read port SHALL return wb_data in the same cycle.
REQ-022 Both read ports SHALL bypass independently; rs_num=rt_num=write address returns wb_data on both ports.
REQ-023 With reg_write_WB=0, no bypass occurs and no state changes, whatever the other WB inputs are.
REQ-024 write_count SHALL increment by 1 on every committed write (REQ-018) and wrap from 0xFFFFFFFF to 0.
REQ-025 Back-to-back writes to the same register SHALL each commit; the last write wins.

Reset
REQ-026 When reset=1 at a rising edge, all registers and write_count SHALL become 0, and any concurrent write is discarded.
REQ-027 During reset assertion, rs_data and rt_data SHALL reflect stored contents (0 after the first edge); the bypass path stays active while reset is high.
REQ-028 Reset asserted mid-sequence SHALL take priority over a commit on that edge; state is identical to a power-on reset.

Verification
REQ-029 Reset, then read all 32 addresses -> every value 0, write_count=0.
REQ-030 Write r5 with src=0, Source_1=0x1234_5678; next cycle rs_num=5 -> rs_data=0x1234_5678, write_count=1.
REQ-031 Write r7 with src=1, Source_2=0xDEAD_BEEF, rt_num=7 in the same cycle -> rt_data=0xDEAD_BEEF before the edge (bypass); value persists after the edge.
REQ-032 SLT write to r3 with STL_WB=1, Source_1=0xFFFF_FFFF -> r3=0x0000_0001; with STL_WB=0 -> r3=0.
REQ-033 Write r0 with 0xAAAA_AAAA and rs_num=0 -> rs_data=0 in the same and next cycles, write_count unchanged.
REQ-034 Assert reset in the same cycle as a write to r9=0x55 -> r9=0 and write_count=0 after the edge.
